// File: rtl/audio_recorder.sv
// Record-and-playback buffer: mixes stereo ADC frames to mono, stores them in
// a block RAM while recording, and replays one stored sample per frame.
module audio_recorder #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  record,
   input  logic                  play_stop,
   input  logic                  NewFrame,
   input  logic [23:0]           LeftRecData,
   input  logic [23:0]           RightRecData,
   output logic [15:0]           sample,
   output logic                  recording,
   output logic                  playing,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   rec_len
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RECORD = 2'd1,
      S_PLAY   = 2'd2
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [15:0]           r_mem [DEPTH];
   logic [15:0]           r_rd_data;
   logic                  r_rd_pend;

   logic [16:0]           w_sum;
   logic [15:0]           w_mix;
   logic                  w_we;
   logic                  w_re;
   logic                  w_last_wr;
   logic                  w_last_rd;

   // Sign-extended 17-bit sum; bits [16:1] are the arithmetic half, which cannot overflow
   assign w_sum     = {LeftRecData[23], LeftRecData[23:8]} + {RightRecData[23], RightRecData[23:8]};
   assign w_mix     = w_sum[16:1];
   assign w_we      = !reset && (r_state == S_RECORD) && NewFrame;
   assign w_re      = !reset && (r_state == S_PLAY) && NewFrame && !play_stop;
   assign w_last_wr = &r_wr_ptr;
   assign w_last_rd = ({1'b0, r_rd_ptr} == (rec_len - (ADDR_WIDTH+1)'(1)));

   // Buffer write port
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[r_wr_ptr] <= w_mix;
      end
   end

   // Buffer read port (synchronous, data one cycle after the frame)
   always_ff @(posedge clk) begin
      if (w_re) begin
         r_rd_data <= r_mem[r_rd_ptr];
      end
   end

   // Control FSM with registered status outputs and playback sample register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         recording <= 1'b0;
         playing   <= 1'b0;
         full      <= 1'b0;
         rec_len   <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         sample    <= 16'd0;
         r_rd_pend <= 1'b0;
      end else begin
         r_rd_pend <= w_re;
         // A pending read always wins so the last played word is never lost
         if (r_rd_pend) begin
            sample <= r_rd_data;
         end else if (NewFrame && (r_state != S_PLAY)) begin
            sample <= 16'd0;
         end

         case (r_state)
            S_IDLE: begin
               if (record) begin
                  r_state   <= S_RECORD;
                  recording <= 1'b1;
                  r_wr_ptr  <= '0;
                  rec_len   <= '0;
                  full      <= 1'b0;
               end else if (play_stop && (rec_len != '0)) begin
                  r_state  <= S_PLAY;
                  playing  <= 1'b1;
                  r_rd_ptr <= '0;
               end
            end
            S_RECORD: begin
               if (NewFrame) begin
                  r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
                  rec_len  <= rec_len + (ADDR_WIDTH+1)'(1);
               end
               if (NewFrame && w_last_wr) begin
                  full      <= 1'b1;
                  r_state   <= S_IDLE;
                  recording <= 1'b0;
               end else if (record) begin
                  r_state   <= S_IDLE;
                  recording <= 1'b0;
               end
            end
            S_PLAY: begin
               if (play_stop) begin
                  r_state <= S_IDLE;
                  playing <= 1'b0;
               end else if (NewFrame) begin
                  r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
                  if (w_last_rd) begin
                     r_state <= S_IDLE;
                     playing <= 1'b0;
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               recording <= 1'b0;
               playing   <= 1'b0;
            end
         endcase
      end
   end

endmodule
